// File: rtl/sd_seq_pkg.sv
// Shared register map, command constants and state types for the SD init/read sequencer.
package sd_seq_pkg;
    localparam logic [6:0] REG_START  = 7'h00;
    localparam logic [6:0] REG_ARG1   = 7'h01;
    localparam logic [6:0] REG_ARG2   = 7'h02;
    localparam logic [6:0] REG_ARG3   = 7'h03;
    localparam logic [6:0] REG_FLAGS  = 7'h04;
    localparam logic [6:0] REG_CMD    = 7'h05;
    localparam logic [6:0] REG_CLKDIV = 7'h24;
    localparam logic [6:0] REG_HRST   = 7'h7F;

    localparam logic [7:0] CMD_GO_IDLE     = 8'd0;
    localparam logic [7:0] CMD_ALL_CID     = 8'd2;
    localparam logic [7:0] CMD_SEND_RCA    = 8'd3;
    localparam logic [7:0] CMD_SELECT      = 8'd7;
    localparam logic [7:0] CMD_READ_SINGLE = 8'd17;

    localparam logic [7:0] FLG_NONE = 8'h00;
    localparam logic [7:0] FLG_R1   = 8'h01;
    localparam logic [7:0] FLG_R2   = 8'h02;
    localparam logic [7:0] FLG_READ = 8'h3D;

    typedef enum logic [2:0] {
        ST_IDLE, ST_REGWR, ST_ISSUE, ST_WAIT, ST_CHECK, ST_READY, ST_READ_WAIT, ST_FAIL
    } state_e;

    typedef enum logic [2:0] {
        STEP_HRST_SET, STEP_HRST_CLR, STEP_DIV_INIT, STEP_CMD0,
        STEP_CMD2, STEP_CMD3, STEP_CMD7, STEP_DIV_RUN
    } step_e;

    // arg[31:8] as carried by reg3..reg1; arg[7:0] is always zero on the host side
    function automatic logic [23:0] cmd7_arg(input logic [15:0] rca);
        return {rca, 8'h00};
    endfunction
endpackage

// File: rtl/sd_reg_burst.sv
// Six-write command burst to the host: reg5 (cmd), reg4 (flags), reg3..reg1 (arg), reg0 (start).
module sd_reg_burst
    import sd_seq_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        go_i,
    input  logic [7:0]  cmd_i,
    input  logic [7:0]  flags_i,
    input  logic [23:0] arg_i,
    input  logic        rd_i,
    input  logic        reg_ready_i,
    output logic [6:0]  reg_addr_o,
    output logic [7:0]  reg_wdata_o,
    output logic        reg_we_o,
    output logic        done_o
);
    localparam logic [2:0] LAST_IDX = 3'd5;

    logic [47:0] payload_q, payload_d;
    logic [2:0]  idx_q, idx_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
    logic [7:0]  seq_byte [8];

    // seq_byte[i] is the data of the i-th write, which targets register 5 - i
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
            if (gi < 6) begin : g_used
                assign seq_byte[gi] = payload_q[47 - 8*gi -: 8];
            end else begin : g_pad
                assign seq_byte[gi] = 8'h00;
            end
        end
    endgenerate

    always_comb begin
        payload_d = payload_q;
        idx_d     = idx_q;
        we_d      = we_q;
        done_d    = 1'b0;
        if (go_i && !we_q) begin
            payload_d = {cmd_i, flags_i, arg_i, 7'b0, rd_i};
            idx_d     = 3'd0;
            we_d      = 1'b1;
        end else if (we_q && reg_ready_i) begin
            if (idx_q == LAST_IDX) begin
                we_d   = 1'b0;
                done_d = 1'b1;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            payload_q <= '0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            payload_q <= payload_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            done_q    <= done_d;
        end
    end

    assign reg_we_o    = we_q;
    assign reg_addr_o  = we_q ? (REG_CMD - {4'b0, idx_q}) : 7'h00;
    assign reg_wdata_o = we_q ? seq_byte[idx_q] : 8'h00;
    assign done_o      = done_q;
endmodule

// File: rtl/sd_init_seq.sv
// SD card identification sequencer with retry/timeout handling and single-block read issue.
module sd_init_seq
    import sd_seq_pkg::*;
#(
    parameter logic [7:0] INIT_DIV  = 8'h23,
    parameter logic [7:0] RUN_DIV   = 8'h00,
    parameter int         TIMEOUT   = 65535,
    parameter int         MAX_RETRY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        rd_req_i,
    input  logic [23:0] rd_addr_i,
    output logic        rd_ack_o,
    output logic        rd_done_o,
    output logic        rd_err_o,
    output logic        init_done_o,
    output logic        init_err_o,
    output logic        busy_o,
    output logic [6:0]  reg_addr_o,
    output logic [7:0]  reg_wdata_o,
    output logic        reg_we_o,
    input  logic        reg_ready_i,
    input  logic        host_done_i,
    input  logic        host_err_i,
    input  logic [15:0] host_rca_i
);
    localparam int            TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [7:0]    RETRY_LAST = 8'(MAX_RETRY);

    state_e        state_q;
    step_e         step_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    retry_q;
    logic [15:0]   rca_q;
    logic [23:0]   addr_q;
    logic          sw_we_q, go_q, err_q, rd_issued_q;
    logic          rd_ack_q, rd_done_q, rd_err_q;

    logic [7:0]  cmd_idx, cmd_flags, sw_data;
    logic [23:0] cmd_arg;
    logic        cmd_rd;
    logic [6:0]  sw_addr;
    logic [6:0]  b_addr;
    logic [7:0]  b_wdata;
    logic        b_we, b_done;

    always_comb begin
        cmd_idx   = CMD_GO_IDLE;
        cmd_flags = FLG_NONE;
        cmd_arg   = 24'h0;
        cmd_rd    = 1'b0;
        sw_addr   = REG_HRST;
        sw_data   = 8'h00;
        if (state_q == ST_READ_WAIT) begin
            cmd_idx   = CMD_READ_SINGLE;
            cmd_flags = FLG_READ;
            cmd_arg   = addr_q;
            cmd_rd    = 1'b1;
        end else begin
            unique case (step_q)
                STEP_HRST_SET: sw_data = 8'h01;
                STEP_HRST_CLR: sw_data = 8'h00;
                STEP_DIV_INIT: begin sw_addr = REG_CLKDIV; sw_data = INIT_DIV; end
                STEP_CMD0:     cmd_idx = CMD_GO_IDLE;
                STEP_CMD2:     begin cmd_idx = CMD_ALL_CID;  cmd_flags = FLG_R2; end
                STEP_CMD3:     begin cmd_idx = CMD_SEND_RCA; cmd_flags = FLG_R1; end
                STEP_CMD7:     begin cmd_idx = CMD_SELECT;   cmd_flags = FLG_R1; cmd_arg = cmd7_arg(rca_q); end
                STEP_DIV_RUN:  begin sw_addr = REG_CLKDIV; sw_data = RUN_DIV; end
                default:       ;
            endcase
        end
    end

    sd_reg_burst u_burst (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .go_i        (go_q),
        .cmd_i       (cmd_idx),
        .flags_i     (cmd_flags),
        .arg_i       (cmd_arg),
        .rd_i        (cmd_rd),
        .reg_ready_i (reg_ready_i),
        .reg_addr_o  (b_addr),
        .reg_wdata_o (b_wdata),
        .reg_we_o    (b_we),
        .done_o      (b_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            step_q      <= STEP_HRST_SET;
            tmo_q       <= '0;
            retry_q     <= '0;
            rca_q       <= '0;
            addr_q      <= '0;
            sw_we_q     <= 1'b0;
            go_q        <= 1'b0;
            err_q       <= 1'b0;
            rd_issued_q <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_done_q   <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            go_q      <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_done_q <= 1'b0;
            rd_err_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_READY, ST_FAIL: begin
                    if (start_i) begin
                        state_q <= ST_REGWR;
                        step_q  <= STEP_HRST_SET;
                        sw_we_q <= 1'b1;
                        retry_q <= '0;
                    end else if (state_q == ST_READY && rd_req_i) begin
                        rd_ack_q    <= 1'b1;
                        addr_q      <= rd_addr_i;
                        rd_issued_q <= 1'b0;
                        go_q        <= 1'b1;
                        state_q     <= ST_READ_WAIT;
                    end
                end
                ST_REGWR: begin
                    if (reg_ready_i) begin
                        unique case (step_q)
                            STEP_HRST_SET: step_q <= STEP_HRST_CLR;
                            STEP_HRST_CLR: step_q <= STEP_DIV_INIT;
                            STEP_DIV_INIT: begin
                                step_q  <= STEP_CMD0;
                                sw_we_q <= 1'b0;
                                go_q    <= 1'b1;
                                state_q <= ST_ISSUE;
                            end
                            default: begin
                                sw_we_q <= 1'b0;
                                state_q <= ST_READY;
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    if (b_done) begin
                        tmo_q   <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // a done arriving on the timeout cycle wins over the timeout
                    if (host_done_i) begin
                        err_q   <= host_err_i;
                        state_q <= ST_CHECK;
                        if (step_q == STEP_CMD3 && !host_err_i) rca_q <= host_rca_i;
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ST_CHECK;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (!err_q) begin
                        retry_q <= '0;
                        if (step_q == STEP_CMD7) begin
                            step_q  <= STEP_DIV_RUN;
                            sw_we_q <= 1'b1;
                            state_q <= ST_REGWR;
                        end else begin
                            step_q  <= step_e'(step_q + 3'd1);
                            go_q    <= 1'b1;
                            state_q <= ST_ISSUE;
                        end
                    end else if (retry_q == RETRY_LAST) begin
                        state_q <= ST_FAIL;
                    end else begin
                        retry_q <= retry_q + 8'd1;
                        go_q    <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_READ_WAIT: begin
                    // host_done_i only counts once the CMD17 burst has gone out
                    if (!rd_issued_q) begin
                        if (b_done) begin
                            rd_issued_q <= 1'b1;
                            tmo_q       <= '0;
                        end
                    end else if (host_done_i || tmo_q == TMO_LAST) begin
                        rd_done_q <= 1'b1;
                        rd_err_q  <= host_done_i ? host_err_i : 1'b1;
                        state_q   <= ST_READY;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = ~rst_i & ~(state_q inside {ST_IDLE, ST_READY, ST_FAIL});
    assign init_done_o = ~rst_i & (state_q inside {ST_READY, ST_READ_WAIT});
    assign init_err_o  = ~rst_i & (state_q == ST_FAIL);
    assign rd_ack_o    = ~rst_i & rd_ack_q;
    assign rd_done_o   = ~rst_i & rd_done_q;
    assign rd_err_o    = ~rst_i & rd_err_q;
    assign reg_we_o    = ~rst_i & (sw_we_q | b_we);
    assign reg_addr_o  = rst_i ? 7'h00 : (b_addr | (sw_we_q ? sw_addr : 7'h00));
    assign reg_wdata_o = rst_i ? 8'h00 : (b_wdata | (sw_we_q ? sw_data : 8'h00));
endmodule

// File: tb/tb_sd_init_seq.sv
// Scoreboard bench for sd_init_seq: expected register writes and read completions are queued, a monitor checks them.
module tb_sd_init_seq;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst_i, start_i, rd_req_i, reg_ready_i;
    logic [23:0] rd_addr_i;
    logic        host_done_i, host_err_i;
    logic [15:0] host_rca_i;
    logic        rd_ack_o, rd_done_o, rd_err_o, init_done_o, init_err_o, busy_o, reg_we_o;
    logic [6:0]  reg_addr_o;
    logic [7:0]  reg_wdata_o;

    always #5 clk = ~clk;

    sd_init_seq #(.INIT_DIV(8'h23), .RUN_DIV(8'h00), .TIMEOUT(TMO), .MAX_RETRY(3)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i),
        .rd_ack_o(rd_ack_o), .rd_done_o(rd_done_o), .rd_err_o(rd_err_o),
        .init_done_o(init_done_o), .init_err_o(init_err_o), .busy_o(busy_o),
        .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_we_o(reg_we_o),
        .reg_ready_i(reg_ready_i), .host_done_i(host_done_i), .host_err_i(host_err_i),
        .host_rca_i(host_rca_i)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [14:0] expq[$];
    logic        rd_expq[$];
    logic [7:0]  issued[$];
    int          reg0_cyc[$];
    int          n_writes = 0;
    int          ack_cnt = 0;
    int          cyc = 0;
    int          cmd0_drop = 0;
    int          cmd2_errs = 0;
    logic [7:0]  cur_cmd = 8'h00;
    logic [7:0]  host_cmd;
    logic [14:0] mon_exp;
    logic        mon_rexp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_w(input logic [6:0] a, input logic [7:0] d);
        expq.push_back({a, d});
    endtask

    task automatic push_cmd(input logic [7:0] c, input logic [7:0] f, input logic [7:0] b3,
                            input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] st);
        push_w(7'h05, c); push_w(7'h04, f); push_w(7'h03, b3);
        push_w(7'h02, b2); push_w(7'h01, b1); push_w(7'h00, st);
    endtask

    task automatic push_init(input int n_cmd0, input int n_cmd2, input bit full);
        push_w(7'h7F, 8'h01); push_w(7'h7F, 8'h00); push_w(7'h24, 8'h23);
        repeat (n_cmd0) push_cmd(8'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (n_cmd2) push_cmd(8'd2, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00);
        if (full) begin
            push_cmd(8'd3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
            push_cmd(8'd7, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00);
            push_w(7'h24, 8'h00);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    task automatic wait_init(input int budget, input string name);
        int i;
        for (i = 0; i < budget && !(init_done_o || init_err_o); i++) @(negedge clk);
        if (!(init_done_o || init_err_o)) begin
            vectors++; miscompares++;
            $display("FAIL %s: no init_done_o/init_err_o within %0d cycles", name, budget);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {rd_ack_o, rd_done_o, rd_err_o, init_done_o, init_err_o, busy_o,
                     reg_we_o, reg_addr_o, reg_wdata_o}, 32'h0);
    endtask

    // Monitor: every completed write is popped against the expected trace.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reg_we_o && reg_ready_i) begin
                n_writes++;
                $display("[%0d] write reg %02h <= %02h", cyc, reg_addr_o, reg_wdata_o);
                if (expq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_write: got reg %02h <= %02h, expected no write", reg_addr_o, reg_wdata_o);
                end else begin
                    mon_exp = expq.pop_front();
                    check("write_trace", {17'd0, reg_addr_o, reg_wdata_o}, {17'd0, mon_exp});
                end
                if (reg_addr_o == 7'h05) cur_cmd = reg_wdata_o;
                if (reg_addr_o == 7'h00) begin
                    issued.push_back(cur_cmd);
                    reg0_cyc.push_back(cyc);
                end
            end
            if (rd_ack_o) ack_cnt++;
            if (rd_done_o) begin
                $display("[%0d] read done err=%0b", cyc, rd_err_o);
                if (rd_expq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_rd_done: got rd_done_o=1, expected none");
                end else begin
                    mon_rexp = rd_expq.pop_front();
                    check("rd_err", {31'd0, rd_err_o}, {31'd0, mon_rexp});
                end
            end
        end
    end

    // Host model: answers each issued command two cycles after the burst ends.
    initial begin
        host_done_i = 1'b0; host_err_i = 1'b0; host_rca_i = 16'h0013;
        forever begin
            @(posedge clk); #2;
            host_done_i = 1'b0; host_err_i = 1'b0;
            if (issued.size() > 0) begin
                host_cmd = issued.pop_front();
                if (host_cmd == 8'd0 && cmd0_drop > 0) begin
                    cmd0_drop--;
                end else begin
                    repeat (2) @(posedge clk);
                    #2 host_done_i = 1'b1;
                    if (host_cmd == 8'd2 && cmd2_errs > 0) begin
                        host_err_i = 1'b1;
                        cmd2_errs--;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int i;
        rst_i = 1'b1; start_i = 1'b0; rd_req_i = 1'b0; rd_addr_i = 24'h0; reg_ready_i = 1'b1;
        repeat (3) begin @(negedge clk); check_all_zero("reset_outputs"); end
        @(posedge clk); #1 rst_i = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_levels", {29'd0, init_done_o, init_err_o, busy_o}, 32'h0);

        // Nominal init with a 5-cycle reg_ready_i stall inside the CMD0 burst
        push_init(1, 1, 1'b1);
        pulse_start();
        for (i = 0; i < 50 && n_writes < 5; i++) @(posedge clk);
        #1 reg_ready_i = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_hold", {16'd0, reg_we_o, reg_addr_o, reg_wdata_o}, {16'd0, 1'b1, 7'h03, 8'h00});
        end
        @(posedge clk); #1 reg_ready_i = 1'b1;
        wait_init(200, "init_nominal");
        check("init_nominal_levels", {29'd0, init_done_o, init_err_o, busy_o}, 32'b100);
        check("init_nominal_trace_left", expq.size(), 0);

        // Block read at 24'h000102
        push_cmd(8'd17, 8'h3D, 8'h00, 8'h01, 8'h02, 8'h01);
        rd_expq.push_back(1'b0);
        a0 = ack_cnt;
        @(posedge clk); #1 rd_addr_i = 24'h000102; rd_req_i = 1'b1;
        @(posedge clk); #1 rd_req_i = 1'b0;
        @(negedge clk);
        check("rd_ack", {31'd0, rd_ack_o}, 32'd1);
        for (i = 0; i < 100 && rd_expq.size() != 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("rd_done_count_left", rd_expq.size(), 0);
        check("rd_ack_count", ack_cnt - a0, 1);
        check("rd_trace_left", expq.size(), 0);
        check("ready_after_read", {30'd0, init_done_o, busy_o}, 32'b10);

        // Restart from READY; CMD2 fails twice then succeeds
        cmd2_errs = 2;
        push_init(1, 3, 1'b1);
        pulse_start();
        @(negedge clk);
        check("restart_clears_done", {31'd0, init_done_o}, 32'd0);
        wait_init(300, "init_cmd2_retry");
        check("cmd2_retry_levels", {29'd0, init_done_o, init_err_o, busy_o}, 32'b100);
        check("cmd2_retry_trace_left", expq.size(), 0);

        // CMD2 fails on every issue: 1 + 3 re-issues, then FAIL
        cmd2_errs = 4;
        push_init(1, 4, 1'b0);
        pulse_start();
        wait_init(300, "init_cmd2_fail");
        repeat (3) @(negedge clk);
        check("fail_levels", {29'd0, init_done_o, init_err_o, busy_o}, 32'b010);
        check("fail_trace_left", expq.size(), 0);

        // Read request in FAIL is ignored
        a0 = ack_cnt;
        @(posedge clk); #1 rd_addr_i = 24'hABCDEF; rd_req_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rd_req_i = 1'b0;
        repeat (3) @(negedge clk);
        check("fail_rd_ignored", ack_cnt - a0, 0);
        check("fail_still_err", {31'd0, init_err_o}, 32'd1);

        // First CMD0 gets no answer: reissued after TMO wait cycles
        cmd0_drop = 1;
        reg0_cyc.delete();
        push_init(2, 1, 1'b1);
        pulse_start();
        wait_init(500, "init_timeout");
        check("timeout_levels", {29'd0, init_done_o, init_err_o, busy_o}, 32'b100);
        check("timeout_reg0_count", reg0_cyc.size(), 5);
        // reg0 to reg0: 2 cycles into WAIT, TMO waiting, 1 CHECK, 6 burst writes
        if (reg0_cyc.size() >= 2)
            check("timeout_gap", reg0_cyc[1] - reg0_cyc[0], TMO + 9);

        // Reset in the middle of the CMD3 burst, then a fresh start
        push_init(1, 1, 1'b0);
        push_w(7'h05, 8'd3); push_w(7'h04, 8'h01);
        pulse_start();
        for (i = 0; i < 200 && expq.size() != 0; i++) @(posedge clk);
        if (expq.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL reset_setup: got %0d writes pending, expected 0", expq.size());
        end
        #1 rst_i = 1'b1;
        repeat (3) begin @(negedge clk); check_all_zero("midburst_reset_outputs"); end
        @(posedge clk); #1 rst_i = 1'b0;
        repeat (5) @(negedge clk);
        check("post_reset_idle", {28'd0, init_done_o, init_err_o, busy_o, reg_we_o}, 32'h0);
        push_init(1, 1, 1'b1);
        pulse_start();
        wait_init(200, "init_after_reset");
        check("after_reset_levels", {29'd0, init_done_o, init_err_o, busy_o}, 32'b100);
        check("after_reset_trace_left", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sd_init_seq.md
SD_INIT_SEQ -- requirements
Module: sd_init_seq

Interface
REQ-001 The module SHALL have parameter INIT_DIV, default 8'h23, the clock-divider value written for card identification.
REQ-002 The module SHALL have parameter RUN_DIV, default 8'h00, the clock-divider value written after init.
REQ-003 The module SHALL have parameter TIMEOUT, default 65535, the maximum cycles to wait for host_done_i per command.
REQ-004 The module SHALL have parameter MAX_RETRY, default 3, the number of re-issues per command before failure.
REQ-005 The module SHALL have port clk_i, input, 1, the single clock.
REQ-006 The module SHALL have port rst_i, input, 1, a synchronous active-high reset.
REQ-007 The module SHALL have port start_i, input, 1, a pulse that begins init from IDLE, READY or FAIL.
REQ-008 The module SHALL have ports rd_req_i (input, 1) and rd_addr_i (input, 24), a block-read request and its address.
REQ-009 The module SHALL have outputs rd_ack_o, rd_done_o and rd_err_o (1 each): accept pulse, completion pulse, error flag valid with rd_done_o.
REQ-010 The module SHALL have outputs init_done_o, init_err_o and busy_o (1 each), all level signals.
REQ-011 The module SHALL have outputs reg_addr_o (7), reg_wdata_o (8) and reg_we_o (1), the host register write port.
REQ-012 The module SHALL have input reg_ready_i (1); a write completes on a cycle with reg_we_o & reg_ready_i.
REQ-013 The module SHALL have inputs host_done_i (1, pulse), host_err_i (1, valid with done) and host_rca_i (16, valid with the CMD3 done).

Function
REQ-014 The host register map SHALL be: 0 start (wdata 0 = cmd only, 1 = cmd + data read); 1/2/3 = arg[15:8]/[23:16]/[31:24], with arg[7:0] fixed at 0; 4 flags; 5 cmd index; 7'h24 clock divider; 7'h7F host reset.
REQ-015 Each command SHALL be issued as six writes in the order reg5, reg4, reg3, reg2, reg1, reg0; reg_we_o SHALL hold its address and data stable while reg_ready_i is low.
REQ-016 The init sequence SHALL be: 7'h7F<=1; 7'h7F<=0; 7'h24<=INIT_DIV; CMD0 (flags 8'h00, arg 0); CMD2 (8'h02); CMD3 (8'h01, RCA latched); CMD7 (8'h01, arg = {RCA, 16'h0}); 7'h24<=RUN_DIV; then READY.
REQ-017 The FSM states SHALL be IDLE, REGWR, ISSUE, WAIT, CHECK, READY, READ_WAIT and FAIL.
REQ-018 After the reg0 write the FSM SHALL enter WAIT and clear the timeout counter; host_done_i with host_err_i=0 advances to the next step.
REQ-019 Error or timeout SHALL re-issue the same command; after MAX_RETRY re-issues the FSM SHALL go to FAIL with init_err_o=1.
REQ-020 host_done_i and timeout in the same cycle SHALL resolve as done.
REQ-021 In READY with rd_req_i=1, the block SHALL pulse rd_ack_o for 1 cycle, latch rd_addr_i and issue CMD17 (flags 8'h3D, reg3..1 = addr[23:16], [15:8], [7:0]; reg0 wdata 1).
REQ-022 CMD17 completion or timeout SHALL pulse rd_done_o once, with rd_err_o = host_err_i | timeout; CMD17 SHALL NOT be retried, and the FSM SHALL return to READY.
REQ-023 rd_req_i outside READY SHALL be ignored, with no ack.
REQ-024 start_i SHALL be ignored unless the FSM is in IDLE, READY or FAIL; a restart SHALL clear init_done_o and init_err_o.
REQ-025 host_done_i outside WAIT or READ_WAIT SHALL be ignored.
REQ-026 busy_o SHALL be 1 in every state except IDLE, READY and FAIL; init_done_o SHALL be 1 only in READY and READ_WAIT.
REQ-027 reg_we_o SHALL never be asserted in IDLE, READY or FAIL.

Reset
REQ-028 rst_i SHALL, at any time including mid-burst, force IDLE and clear all counters and the latched RCA/address.
REQ-029 During rst_i every output SHALL be 0, and no partial burst SHALL be resumed after rst_i deasserts.

Structure
REQ-030 The package sd_seq_pkg SHALL hold the register addresses, command indices, flag bytes, the FSM state enum and the init-step enum.
REQ-031 The sub-module sd_reg_burst SHALL perform the six-write sequence with a write index and reg_ready_i stall, and pulse its done output after the reg0 write.

Verification
REQ-032 start_i, host always done OK, RCA 16'h0013 -> exact write trace per REQ-016, CMD7 reg2=8'h13, reg3=8'h00, then init_done_o=1.
REQ-033 host_err_i on the first two CMD2 dones -> CMD2 issued 3 times, init completes; errors on all 4 -> FAIL, init_err_o=1.
REQ-034 CMD0 with no host_done_i -> re-issue after TIMEOUT cycles (TIMEOUT=100 in bench).
REQ-035 READY, rd_addr_i=24'h000102 -> reg3=8'h00, reg2=8'h01, reg1=8'h02, reg4=8'h3D, reg0=1, then one rd_done_o with rd_err_o=0.
REQ-036 reg_ready_i low 5 cycles mid-burst -> address and data held, no write lost or duplicated.
REQ-037 rst_i during the CMD3 burst, then start_i -> outputs 0 during reset, then a fresh sequence starting at the 7'h7F write.
